multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM for the multicycle MIPS datapath. It sequences one shared memory and one ALU across fetch, decode, execute, memory and writeback steps, driving per-state datapath strobes and mux selects. It replaces the single-cycle main decoder when the datapath is built around a single unified memory with variable latency. The ALU decoder consumes aluop unchanged, and funct decode stays external.

Parameters:
OPW, 6, opcode width
STW, 4, state encoding width (exported on dbg_state)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH
op  in  OPW  opcode field from instruction register (IR[31:26])
zero  in  1  ALU zero flag (used by datapath branch logic; passed through for debug only)
mem_ready  in  1  memory access completes this cycle
irwrite  out  1  load instruction register
pcwrite  out  1  unconditional PC write
branch  out  1  conditional PC write (datapath ANDs with zero)
memwrite  out  1  memory write strobe
iord  out  1  memory address select: 0=PC, 1=ALUOut
memtoreg  out  1  writeback source: 1=memory data register
regdst  out  1  destination register: 1=rd, 0=rt
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=regA
alusrcb  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
aluop  out  2  00=add, 01=sub, 10=funct
byte_enable  out  1  byte-wide memory access (LB/SB)
halted  out  1  illegal or stop opcode reached
dbg_state  out  STW  current state code

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, LB 100000, SB 101000, BEQ 000100, ADDI 001000, J 000010. Every other opcode, including 111111, is illegal.
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, HALT 12.
- Reset: state is FETCH. op_q is 0. All outputs are driven combinationally from the state, so FETCH strobes appear immediately except those gated by mem_ready.
- Reset mid-instruction: the state returns to FETCH asynchronously. Partially sequenced writes are abandoned with no further strobes.
- Every output not listed for a state is 0. No outputs are ever X.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite equal mem_ready.
  - The state holds until mem_ready=1, then goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Captures op into op_q. Next state:
  - LW, SW, LB or SB -> MEMADR
  - RTYPE -> RTYPEEX
  - BEQ -> BEQEX
  - ADDI -> ADDIEX
  - J -> JEX
  - illegal -> HALT
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Loads (LW/LB) -> MEMRD; stores (SW/SB) -> MEMWR.
- MEMRD: iord=1, byte_enable=(op_q==LB). Holds until mem_ready, then goes to MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite=1, byte_enable=(op_q==LB). Next state FETCH.
- MEMWR: iord=1, byte_enable=(op_q==SB).
  - memwrite equals mem_ready, giving exactly one write pulse.
  - Holds until mem_ready, then goes to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next state RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JEX: pcsrc=10, pcwrite=1. Next state FETCH.
- HALT: halted=1, all strobes 0. The state is absorbing until reset.
- Latency with mem_ready held at 1:
  - BEQ and J: 3 cycles
  - RTYPE, ADDI, SW and SB: 4 cycles
  - LW and LB: 5 cycles
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- op is don't-care outside DECODE. All later decisions use op_q.
- Unreachable state codes 13–15 recover to FETCH on the next edge.

Test Plan:
- Release reset, mem_ready=1, op=000000 -> states 0,1,6,7,0. irwrite=pcwrite=1 only in cycle 0; regwrite=regdst=1 only in state 7; aluop=10 in state 6.
- op=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. iord=1 during all state-3 cycles; memtoreg=regwrite=1 in state 4 only.
- op=101000 (SB), mem_ready=0 for 1 cycle in MEMWR -> memwrite=0 then a single 1-cycle memwrite=1. byte_enable=1 in state 5; next state 0.
- op=000100, then op=000010 -> BEQEX asserts branch=1, pcsrc=01, aluop=01. JEX asserts pcwrite=1, pcsrc=10. Each instruction takes 3 cycles.
- op=111111 -> DECODE goes to HALT; halted=1 held for 20 cycles with all strobes 0; reset returns the state to FETCH.
- Assert reset asynchronously mid-cycle in MEMWR -> memwrite drops before the next clock edge; dbg_state=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle MIPS datapath that has one unified memory with
// variable latency and one shared ALU. Each instruction is sequenced through
// fetch, decode, execute, memory and writeback steps. Per-state datapath
// strobes and mux selects are decoded from the current state and do not wait
// for a register stage. Where a strobe marks the completion of a memory
// access, it is additionally gated by mem_ready.
//
// Handshake: the memory finishes an access in the cycle where mem_ready=1.
// States that access memory (FETCH, MEMRD, MEMWR) hold until that cycle.
// Strobes that commit the access result (irwrite/pcwrite in FETCH, memwrite
// in MEMWR) are asserted only in that cycle, so each access commits once.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; forces FETCH and clears op_q
//   op           opcode from the instruction register, sampled only in DECODE
//   zero         ALU zero flag; the datapath uses it for branches, unused here
//   mem_ready    memory access completes this cycle
//   irwrite      load instruction register
//   pcwrite      unconditional PC write
//   branch       conditional PC write (datapath ANDs with zero)
//   memwrite     memory write strobe
//   iord         memory address select: 0=PC, 1=ALUOut
//   memtoreg     writeback source: 1=memory data register
//   regdst       destination register: 1=rd, 0=rt
//   regwrite     register file write
//   alusrca      ALU A select: 0=PC, 1=regA
//   alusrcb      ALU B select: 00=regB, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc        PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   aluop        00=add, 01=sub, 10=decode funct
//   byte_enable  byte-wide memory access (LB/SB)
//   halted       illegal opcode reached; FSM parked until reset
//   dbg_state    current state code
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic           memwrite,
    output logic           iord,
    output logic           memtoreg,
    output logic           regdst,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           byte_enable,
    output logic           halted,
    output logic [STW-1:0] dbg_state
);

    // Opcode encodings
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    typedef enum logic [STW-1:0] {
        ST_FETCH   = STW'(0),
        ST_DECODE  = STW'(1),
        ST_MEMADR  = STW'(2),
        ST_MEMRD   = STW'(3),
        ST_MEMWB   = STW'(4),
        ST_MEMWR   = STW'(5),
        ST_RTYPEEX = STW'(6),
        ST_RTYPEWB = STW'(7),
        ST_BEQEX   = STW'(8),
        ST_ADDIEX  = STW'(9),
        ST_ADDIWB  = STW'(10),
        ST_JEX     = STW'(11),
        ST_HALT    = STW'(12)
    } state_t;

    state_t         state;
    logic [OPW-1:0] op_q;

    // The zero flag is consumed by the datapath's branch logic; the
    // controller only carries it for observability.
    logic unused_zero;
    assign unused_zero = zero;

    function automatic logic is_mem_op(input logic [OPW-1:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_LB) || (o == OP_SB);
    endfunction

    function automatic logic is_load(input logic [OPW-1:0] o);
        return (o == OP_LW) || (o == OP_LB);
    endfunction

    // -------------------------------------------------------------------------
    // State sequencing. op is looked at only in DECODE; every later decision
    // uses the captured op_q so the IR can change freely afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            op_q  <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q <= op;
                    if (is_mem_op(op))     state <= ST_MEMADR;
                    else if (op == OP_RTYPE) state <= ST_RTYPEEX;
                    else if (op == OP_BEQ)   state <= ST_BEQEX;
                    else if (op == OP_ADDI)  state <= ST_ADDIEX;
                    else if (op == OP_J)     state <= ST_JEX;
                    else                     state <= ST_HALT;
                end
                // Only loads and stores reach MEMADR.
                ST_MEMADR: state <= is_load(op_q) ? ST_MEMRD : ST_MEMWR;
                ST_MEMRD: begin
                    if (mem_ready) state <= ST_MEMWB;
                end
                ST_MEMWB:   state <= ST_FETCH;
                ST_MEMWR: begin
                    if (mem_ready) state <= ST_FETCH;
                end
                ST_RTYPEEX: state <= ST_RTYPEWB;
                ST_RTYPEWB: state <= ST_FETCH;
                ST_BEQEX:   state <= ST_FETCH;
                ST_ADDIEX:  state <= ST_ADDIWB;
                ST_ADDIWB:  state <= ST_FETCH;
                ST_JEX:     state <= ST_FETCH;
                ST_HALT:    state <= ST_HALT;
                // Codes 13-15 are never entered normally; recover cleanly.
                default:    state <= ST_FETCH;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Everything defaults to 0 so unreachable codes and HALT
    // drive no strobes.
    // -------------------------------------------------------------------------
    always_comb begin
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = 2'b00;
        byte_enable = 1'b0;
        halted      = 1'b0;

        case (state)
            ST_FETCH: begin
                // PC+4 is computed every cycle but only committed, together
                // with the IR load, when the fetch actually completes.
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (signimm << 2).
                alusrcb = 2'b11;
            end
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ST_MEMRD: begin
                iord        = 1'b1;
                byte_enable = (op_q == OP_LB);
            end
            ST_MEMWB: begin
                memtoreg    = 1'b1;
                regwrite    = 1'b1;
                byte_enable = (op_q == OP_LB);
            end
            ST_MEMWR: begin
                // One write pulse, in the cycle the memory accepts it.
                iord        = 1'b1;
                memwrite    = mem_ready;
                byte_enable = (op_q == OP_SB);
            end
            ST_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ST_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ST_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ST_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ST_ADDIWB: begin
                regwrite = 1'b1;
            end
            ST_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed stimulus for multicycle_ctrl. The driver pushes, for every cycle it
// drives, the hand-computed output vector expected in that cycle; a monitor
// on the falling edge pops and compares against the DUT.
//
// Vector layout (21 bits):
//   {dbg_state[3:0],
//    irwrite, pcwrite, branch, memwrite, iord, memtoreg, regdst, regwrite,
//    alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0], byte_enable, halted}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int W = 21;

    // Hand-computed expected vectors, one per state/condition.
    //                                     st     irpwbrmwiomtrdrwa  asb    pcs    aop    be h
    localparam logic [W-1:0] E_FETCH1  = {4'd0,  9'b110000000, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_FETCH0  = {4'd0,  9'b000000000, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_DECODE  = {4'd1,  9'b000000000, 2'b11, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_MEMADR  = {4'd2,  9'b000000001, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_MEMRD   = {4'd3,  9'b000010000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_MEMRD_B = {4'd3,  9'b000010000, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [W-1:0] E_MEMWB   = {4'd4,  9'b000001010, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_MEMWB_B = {4'd4,  9'b000001010, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [W-1:0] E_MEMWR0  = {4'd5,  9'b000010000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_MEMWR1  = {4'd5,  9'b000110000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_MEMWR0B = {4'd5,  9'b000010000, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [W-1:0] E_MEMWR1B = {4'd5,  9'b000110000, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [W-1:0] E_RTEX    = {4'd6,  9'b000000001, 2'b00, 2'b00, 2'b10, 2'b00};
    localparam logic [W-1:0] E_RTWB    = {4'd7,  9'b000000110, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_BEQ     = {4'd8,  9'b001000001, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [W-1:0] E_ADDIEX  = {4'd9,  9'b000000001, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_ADDIWB  = {4'd10, 9'b000000010, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [W-1:0] E_JEX     = {4'd11, 9'b010000000, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [W-1:0] E_HALT    = {4'd12, 9'b000000000, 2'b00, 2'b00, 2'b00, 2'b01};

    // Opcodes; JUNK is driven outside DECODE to show op is ignored there.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ILL   = 6'b111111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] JUNK     = 6'b111111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;

    always #5 clk = ~clk;

    logic       irwrite, pcwrite, branch, memwrite, iord, memtoreg;
    logic       regdst, regwrite, alusrca, byte_enable, halted;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] dbg_state;

    multicycle_ctrl #(.OPW(6), .STW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .irwrite     (irwrite),
        .pcwrite     (pcwrite),
        .branch      (branch),
        .memwrite    (memwrite),
        .iord        (iord),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .aluop       (aluop),
        .byte_enable (byte_enable),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    logic [W-1:0] got;
    assign got = {dbg_state, irwrite, pcwrite, branch, memwrite, iord, memtoreg,
                  regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, byte_enable, halted};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           total  = 0;
    int           passed = 0;

    initial begin
        logic [W-1:0] e;
        string        t;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                total++;
                if (got === e) passed++;
                else $display("FAIL %s: got %b required %b (t=%0t)", t, got, e, $time);
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle's inputs and queues
    // the vector expected during that cycle.
    task automatic cyc(input logic [5:0] o, input logic mr, input logic [W-1:0] e, input string t);
        op        = o;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = JUNK;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(JUNK, 1'b0, E_FETCH0, "reset_hold");
        reset = 1'b0;

        // Fetch stall, then RTYPE: 0,1,6,7
        cyc(JUNK,     1'b0, E_FETCH0, "fetch_stall");
        cyc(JUNK,     1'b1, E_FETCH1, "rt_fetch");
        cyc(OP_RTYPE, 1'b1, E_DECODE, "rt_decode");
        cyc(JUNK,     1'b1, E_RTEX,   "rt_ex");
        cyc(JUNK,     1'b1, E_RTWB,   "rt_wb");

        // LW with two wait cycles in MEMRD: 0,1,2,3,3,3,4
        cyc(JUNK,  1'b1, E_FETCH1, "lw_fetch");
        cyc(OP_LW, 1'b1, E_DECODE, "lw_decode");
        cyc(JUNK,  1'b1, E_MEMADR, "lw_memadr");
        cyc(JUNK,  1'b0, E_MEMRD,  "lw_memrd_w0");
        cyc(JUNK,  1'b0, E_MEMRD,  "lw_memrd_w1");
        cyc(JUNK,  1'b1, E_MEMRD,  "lw_memrd_done");
        cyc(JUNK,  1'b1, E_MEMWB,  "lw_memwb");

        // LB: byte_enable through MEMRD/MEMWB
        cyc(JUNK,  1'b1, E_FETCH1,  "lb_fetch");
        cyc(OP_LB, 1'b1, E_DECODE,  "lb_decode");
        cyc(JUNK,  1'b1, E_MEMADR,  "lb_memadr");
        cyc(JUNK,  1'b1, E_MEMRD_B, "lb_memrd");
        cyc(JUNK,  1'b1, E_MEMWB_B, "lb_memwb");

        // SB with one wait in MEMWR: single write pulse
        cyc(JUNK,  1'b1, E_FETCH1,  "sb_fetch");
        cyc(OP_SB, 1'b1, E_DECODE,  "sb_decode");
        cyc(JUNK,  1'b1, E_MEMADR,  "sb_memadr");
        cyc(JUNK,  1'b0, E_MEMWR0B, "sb_memwr_wait");
        cyc(JUNK,  1'b1, E_MEMWR1B, "sb_memwr_done");

        // SW, no waits
        cyc(JUNK,  1'b1, E_FETCH1, "sw_fetch");
        cyc(OP_SW, 1'b1, E_DECODE, "sw_decode");
        cyc(JUNK,  1'b1, E_MEMADR, "sw_memadr");
        cyc(JUNK,  1'b1, E_MEMWR1, "sw_memwr");

        // BEQ then J, three cycles each
        cyc(JUNK,   1'b1, E_FETCH1, "beq_fetch");
        cyc(OP_BEQ, 1'b1, E_DECODE, "beq_decode");
        cyc(JUNK,   1'b1, E_BEQ,    "beq_ex");
        cyc(JUNK,   1'b1, E_FETCH1, "j_fetch");
        cyc(OP_J,   1'b1, E_DECODE, "j_decode");
        cyc(JUNK,   1'b1, E_JEX,    "j_ex");

        // ADDI
        cyc(JUNK,    1'b1, E_FETCH1, "addi_fetch");
        cyc(OP_ADDI, 1'b1, E_DECODE, "addi_decode");
        cyc(JUNK,    1'b1, E_ADDIEX, "addi_ex");
        cyc(JUNK,    1'b1, E_ADDIWB, "addi_wb");

        // Illegal 111111 -> HALT, absorbing for 20 cycles, then reset
        cyc(JUNK,   1'b1, E_FETCH1, "ill_fetch");
        cyc(OP_ILL, 1'b1, E_DECODE, "ill_decode");
        for (int i = 0; i < 20; i++)
            cyc((i % 2 == 0) ? OP_RTYPE : OP_J, 1'(i % 3 != 0), E_HALT, $sformatf("halt_%0d", i));
        reset = 1'b1;
        cyc(JUNK, 1'b0, E_FETCH0, "halt_reset");
        reset = 1'b0;

        // Another illegal opcode also halts
        cyc(JUNK,   1'b1, E_FETCH1, "jal_fetch");
        cyc(OP_JAL, 1'b1, E_DECODE, "jal_decode");
        cyc(JUNK,   1'b1, E_HALT,   "jal_halt");
        reset = 1'b1;
        cyc(JUNK, 1'b0, E_FETCH0, "jal_reset");
        reset = 1'b0;

        // Asynchronous reset in the middle of a MEMWR cycle
        cyc(JUNK,  1'b1, E_FETCH1, "ar_fetch");
        cyc(OP_SW, 1'b1, E_DECODE, "ar_decode");
        cyc(JUNK,  1'b1, E_MEMADR, "ar_memadr");
        op        = JUNK;
        mem_ready = 1'b1;
        exp_q.push_back(E_MEMWR1);
        tag_q.push_back("ar_memwr_before");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (memwrite === 1'b0 && dbg_state === 4'd0) passed++;
        else $display("FAIL ar_mid_cycle: memwrite=%b dbg_state=%0d required memwrite=0 dbg_state=0",
                      memwrite, dbg_state);
        @(posedge clk);
        #1;
        cyc(JUNK, 1'b0, E_FETCH0, "ar_hold");
        reset = 1'b0;
        cyc(JUNK, 1'b0, E_FETCH0, "ar_after");
        cyc(JUNK, 1'b1, E_FETCH1, "ar_refetch");

        // Every queued expectation must have been consumed.
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
